// File: rtl/ad7873_responder_if.sv
// Serial link between a touchpad controller and an AD7873-style ADC.
// The controller owns sclk/csb/din; the ADC side owns dout/busy.
`timescale 1ns/1ps
interface ad7873_responder_if;
  logic sclk;
  logic csb;
  logic din;
  logic dout;
  logic busy;

  modport master (
    output sclk,
    output csb,
    output din,
    input  dout,
    input  busy
  );

  modport slave (
    input  sclk,
    input  csb,
    input  din,
    output dout,
    output busy
  );
endinterface

// File: rtl/ad7873_responder.sv
// AD7873 serial-side emulator: decodes the control byte, signals busy for one
// sclk period, then returns the addressed 12-bit sample MSB first.
`timescale 1ns/1ps
module ad7873_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     cclk,
  input  logic                     rst,
  ad7873_responder_if.slave        spi,
  input  logic [11:0]              x_value,
  input  logic [11:0]              y_value,
  input  logic [11:0]              z_value,
  output logic [7:0]               cmd_byte,
  output logic                     frame_done,
  output logic                     bad_addr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  localparam logic [2:0] ADDR_X = 3'b101;
  localparam logic [2:0] ADDR_Y = 3'b001;
  localparam logic [2:0] ADDR_Z = 3'b011;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] csb_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   sclk_d;

  logic sclk_s;
  logic csb_s;
  logic din_s;
  logic rise;
  logic fall;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [6:0]  cmd_sr;
  logic [11:0] out_sr;
  logic        dout_r;
  logic        busy_r;

  logic [7:0]  next_byte;
  logic [11:0] sel_value;
  logic        sel_valid;

  // csb idles deselected so a reset never looks like a live chip select.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      csb_sync  <= '1;
      din_sync  <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], spi.csb};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], spi.din};
      sclk_d    <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign csb_s  = csb_sync[SYNC_STAGES-1];
  assign din_s  = din_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d;
  assign fall   = ~sclk_s & sclk_d;

  // Byte as it stands once the bit arriving on this rise is included.
  assign next_byte = {cmd_sr, din_s};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    sel_value = 12'h000;
    sel_valid = 1'b0;
    case (next_byte[6:4])
      ADDR_X: begin
        sel_value = x_value;
        sel_valid = 1'b1;
      end
      ADDR_Y: begin
        sel_value = y_value;
        sel_valid = 1'b1;
      end
      ADDR_Z: begin
        sel_value = z_value;
        sel_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cmd_sr     <= '0;
      out_sr     <= '0;
      dout_r     <= 1'b0;
      busy_r     <= 1'b0;
      cmd_byte   <= 8'h00;
      frame_done <= 1'b0;
      bad_addr   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      bad_addr   <= 1'b0;
      if (csb_s) begin
        // Deselect dominates any sclk edge seen on the same cycle.
        state  <= ST_IDLE;
        cnt    <= '0;
        dout_r <= 1'b0;
        busy_r <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise && din_s) begin
              cmd_sr <= 7'd1;
              cnt    <= 4'd1;
              state  <= ST_CMD;
            end
          end

          ST_CMD: begin
            if (rise) begin
              cmd_sr <= {cmd_sr[5:0], din_s};
              cnt    <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                cmd_byte <= next_byte;
                out_sr   <= sel_value;
                bad_addr <= ~sel_valid;
                state    <= ST_BUSY;
              end
            end
          end

          ST_BUSY: begin
            if (fall) begin
              if (!busy_r) begin
                busy_r <= 1'b1;
              end else begin
                busy_r <= 1'b0;
                dout_r <= out_sr[11];
                out_sr <= {out_sr[10:0], 1'b0};
                cnt    <= 4'd1;
                state  <= ST_DATA;
              end
            end
          end

          ST_DATA: begin
            if (fall) begin
              if (cnt < 4'd12) begin
                dout_r <= out_sr[11];
                out_sr <= {out_sr[10:0], 1'b0};
                cnt    <= cnt + 4'd1;
              end else begin
                // D0 has been held through its rise; this fall ends the frame.
                dout_r     <= 1'b0;
                frame_done <= 1'b1;
                cnt        <= '0;
                state      <= ST_IDLE;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi.dout = dout_r;
  assign spi.busy = busy_r;

endmodule

// File: tb/tb_ad7873_responder.sv
// Directed bench for ad7873_responder: plays the touchpad controller with a
// 12-cclk sclk half-period and checks each read against hand-derived values.
`timescale 1ns/1ps
module tb_ad7873_responder;
  localparam int H = 12;

  logic        cclk = 1'b0;
  logic        rst  = 1'b0;
  logic [11:0] x_value;
  logic [11:0] y_value;
  logic [11:0] z_value;
  logic [7:0]  cmd_byte;
  logic        frame_done;
  logic        bad_addr;

  int vectors     = 0;
  int miscompares = 0;
  int fd_cnt      = 0;
  int bad_cnt     = 0;
  int busy_cyc    = 0;

  ad7873_responder_if spi();

  ad7873_responder #(.SYNC_STAGES(2)) dut (
    .cclk       (cclk),
    .rst        (rst),
    .spi        (spi),
    .x_value    (x_value),
    .y_value    (y_value),
    .z_value    (z_value),
    .cmd_byte   (cmd_byte),
    .frame_done (frame_done),
    .bad_addr   (bad_addr)
  );

  always #5 cclk = ~cclk;

  always @(negedge cclk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (bad_addr === 1'b1) bad_cnt++;
    if (spi.busy === 1'b1) busy_cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic half();
    repeat (H) @(posedge cclk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    spi.din = b;
    half();
    spi.sclk = 1'b1;
    half();
    spi.sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] cmd, input int zeros);
    for (int i = 0; i < zeros; i++) send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
    spi.din = 1'b0;
  endtask

  // Control byte plus the two busy-phase falls; bm is busy between them.
  task automatic send_cmd(input logic [7:0] cmd, input int zeros, output logic bm);
    send_byte(cmd, zeros);
    half();
    bm = spi.busy;
    spi.sclk = 1'b1;
    half();
    spi.sclk = 1'b0;
  endtask

  // Controller samples dout just before each rising edge.
  task automatic read_bits(input int n, output logic [11:0] data);
    data = '0;
    for (int i = 0; i < n; i++) begin
      half();
      data = {data[10:0], spi.dout};
      spi.sclk = 1'b1;
      half();
      spi.sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge cclk);
    #1;
    vectors++;
    if (spi.dout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dout: got %b required 0", spi.dout);
    end
    vectors++;
    if (spi.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b required 0", spi.busy);
    end
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_frame_done: got %b required 0", frame_done);
    end
    vectors++;
    if (bad_addr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bad_addr: got %b required 0", bad_addr);
    end
    vectors++;
    if (cmd_byte !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_cmd_byte: got %h required 00", cmd_byte);
    end
    rst = 1'b0;
    half();
  endtask

  task automatic test_x_read();
    logic [11:0] data;
    logic        bm;
    int          fd0, bad0, bc0;
    x_value = 12'hA5C;
    spi.csb = 1'b0;
    half();
    fd0 = fd_cnt; bad0 = bad_cnt; bc0 = busy_cyc;
    send_cmd(8'hD3, 0, bm);
    // Sample was latched at the 8th rise; later changes must not leak in.
    x_value = 12'h3C3;
    read_bits(12, data);
    half();
    x_value = 12'hA5C;
    vectors++;
    if (data !== 12'hA5C) begin
      miscompares++;
      $display("FAIL x_read_data: got %h required a5c", data);
    end
    vectors++;
    if (bm !== 1'b1) begin
      miscompares++;
      $display("FAIL x_read_busy_mid: got %b required 1", bm);
    end
    vectors++;
    if (busy_cyc - bc0 != 2 * H) begin
      miscompares++;
      $display("FAIL x_read_busy_len: got %0d cclk required %0d", busy_cyc - bc0, 2 * H);
    end
    vectors++;
    if (cmd_byte !== 8'hD3) begin
      miscompares++;
      $display("FAIL x_read_cmd_byte: got %h required d3", cmd_byte);
    end
    vectors++;
    if (fd_cnt - fd0 != 1) begin
      miscompares++;
      $display("FAIL x_read_frame_done: got %0d pulses required 1", fd_cnt - fd0);
    end
    vectors++;
    if (bad_cnt - bad0 != 0) begin
      miscompares++;
      $display("FAIL x_read_bad_addr: got %0d pulses required 0", bad_cnt - bad0);
    end
    vectors++;
    if (spi.dout !== 1'b0) begin
      miscompares++;
      $display("FAIL x_read_dout_idle: got %b required 0", spi.dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] d1, d2;
    logic        bm;
    int          fd0, bad0;
    y_value = 12'h3F1;
    z_value = 12'h801;
    fd0 = fd_cnt; bad0 = bad_cnt;
    send_cmd(8'h93, 0, bm);
    read_bits(12, d1);
    send_cmd(8'hB3, 0, bm);
    read_bits(12, d2);
    half();
    vectors++;
    if (d1 !== 12'h3F1) begin
      miscompares++;
      $display("FAIL b2b_y_data: got %h required 3f1", d1);
    end
    vectors++;
    if (d2 !== 12'h801) begin
      miscompares++;
      $display("FAIL b2b_z_data: got %h required 801", d2);
    end
    vectors++;
    if (fd_cnt - fd0 != 2) begin
      miscompares++;
      $display("FAIL b2b_frame_done: got %0d pulses required 2", fd_cnt - fd0);
    end
    vectors++;
    if (cmd_byte !== 8'hB3) begin
      miscompares++;
      $display("FAIL b2b_cmd_byte: got %h required b3", cmd_byte);
    end
    vectors++;
    if (bad_cnt - bad0 != 0) begin
      miscompares++;
      $display("FAIL b2b_bad_addr: got %0d pulses required 0", bad_cnt - bad0);
    end
  endtask

  task automatic test_bad_addr();
    logic [11:0] data;
    logic        bm;
    int          fd0, bad0;
    fd0 = fd_cnt; bad0 = bad_cnt;
    send_cmd(8'hF3, 0, bm);
    read_bits(12, data);
    half();
    vectors++;
    if (data !== 12'h000) begin
      miscompares++;
      $display("FAIL bad_addr_data: got %h required 000", data);
    end
    vectors++;
    if (bad_cnt - bad0 != 1) begin
      miscompares++;
      $display("FAIL bad_addr_pulse: got %0d cclk high required 1", bad_cnt - bad0);
    end
    vectors++;
    if (fd_cnt - fd0 != 1) begin
      miscompares++;
      $display("FAIL bad_addr_frame_done: got %0d pulses required 1", fd_cnt - fd0);
    end
    vectors++;
    if (cmd_byte !== 8'hF3) begin
      miscompares++;
      $display("FAIL bad_addr_cmd_byte: got %h required f3", cmd_byte);
    end
  endtask

  task automatic test_leading_zeros();
    logic [11:0] data;
    logic        bm;
    int          bad0;
    bad0 = bad_cnt;
    send_cmd(8'hD3, 5, bm);
    read_bits(12, data);
    half();
    vectors++;
    if (data !== 12'hA5C) begin
      miscompares++;
      $display("FAIL lead_zero_data: got %h required a5c", data);
    end
    vectors++;
    if (cmd_byte !== 8'hD3) begin
      miscompares++;
      $display("FAIL lead_zero_cmd_byte: got %h required d3", cmd_byte);
    end
    vectors++;
    if (bad_cnt - bad0 != 0) begin
      miscompares++;
      $display("FAIL lead_zero_bad_addr: got %0d pulses required 0", bad_cnt - bad0);
    end
  endtask

  task automatic test_csb_abort();
    logic [11:0] data;
    logic        bm;
    int          fd0;
    fd0 = fd_cnt;
    send_cmd(8'hD3, 0, bm);
    read_bits(5, data);
    half();
    vectors++;
    if (data[4:0] !== 5'b10100) begin
      miscompares++;
      $display("FAIL abort_partial: got %b required 10100", data[4:0]);
    end
    vectors++;
    if (spi.dout !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_d6: got %b required 1", spi.dout);
    end
    spi.csb = 1'b1;
    repeat (3) @(posedge cclk);
    #1;
    vectors++;
    if (spi.dout !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_dout: got %b required 0", spi.dout);
    end
    vectors++;
    if (spi.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy: got %b required 0", spi.busy);
    end
    half();
    half();
    vectors++;
    if (fd_cnt - fd0 != 0) begin
      miscompares++;
      $display("FAIL abort_frame_done: got %0d pulses required 0", fd_cnt - fd0);
    end
    vectors++;
    if (cmd_byte !== 8'hD3) begin
      miscompares++;
      $display("FAIL abort_cmd_hold: got %h required d3", cmd_byte);
    end
    spi.csb = 1'b0;
    half();
    send_cmd(8'h93, 0, bm);
    read_bits(12, data);
    half();
    vectors++;
    if (data !== 12'h3F1) begin
      miscompares++;
      $display("FAIL abort_next_data: got %h required 3f1", data);
    end
    vectors++;
    if (fd_cnt - fd0 != 1) begin
      miscompares++;
      $display("FAIL abort_next_frame_done: got %0d pulses required 1", fd_cnt - fd0);
    end
  endtask

  task automatic test_rst_busy();
    logic [11:0] data;
    logic        bm;
    int          fd0;
    send_byte(8'hD3, 0);
    half();
    vectors++;
    if (spi.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_busy_pre: got %b required 1", spi.busy);
    end
    rst = 1'b1;
    #2;
    vectors++;
    if (spi.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_busy_async: got %b required 0", spi.busy);
    end
    vectors++;
    if (cmd_byte !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_cmd_byte: got %h required 00", cmd_byte);
    end
    repeat (2) @(posedge cclk);
    #1;
    rst = 1'b0;
    half();
    fd0 = fd_cnt;
    send_cmd(8'hD3, 0, bm);
    read_bits(12, data);
    half();
    vectors++;
    if (data !== 12'hA5C) begin
      miscompares++;
      $display("FAIL rst_after_data: got %h required a5c", data);
    end
    vectors++;
    if (fd_cnt - fd0 != 1) begin
      miscompares++;
      $display("FAIL rst_after_frame_done: got %0d pulses required 1", fd_cnt - fd0);
    end
  endtask

  initial begin
    spi.sclk = 1'b0;
    spi.csb  = 1'b1;
    spi.din  = 1'b0;
    x_value  = 12'h000;
    y_value  = 12'h000;
    z_value  = 12'h000;
    #1;
    rst = 1'b1;
    test_reset();
    test_x_read();
    test_back_to_back();
    test_bad_addr();
    test_leading_zeros();
    test_csb_abort();
    test_rst_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ad7873_responder.md
# ad7873_responder

Synthesizable SPI-style responder that emulates the AD7873 touchscreen ADC on the serial side. It watches sclk/csb/din from the touchpad controller, decodes the 8-bit control byte, and raises busy for one sclk period. It then shifts back the 12-bit sample for the addressed channel. Used for on-board loopback and bench verification of the touchpad controller without the panel attached.

## Interface
- SYNC_STAGES, 2: flops in each input synchronizer (sclk, csb, din); minimum 2.
- cclk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  serial clock from controller; asynchronous to cclk.
- csb  in  1  chip select, active low; asynchronous.
- din  in  1  command bits from controller; sampled on sclk rising edges.
- dout  out  1  result bits to controller; changes after sclk falling edges.
- busy  out  1  conversion-busy flag to controller.
- x_value, y_value, z_value  in  12 each  sample values returned for X/Y/Z reads; quasi-static.
- cmd_byte  out  8  last complete control byte received.
- frame_done  out  1  one-cycle pulse after the 12th data bit is driven.
- bad_addr  out  1  one-cycle pulse when the decoded address is not X/Y/Z.

## Operation
- Each asynchronous input passes through SYNC_STAGES flops, plus one history flop for edge detection. rise = sclk_s & ~sclk_d; fall = ~sclk_s & sclk_d.
- csb_s high forces state IDLE, bit counter 0, dout 0, busy 0 on the next cclk.
  - cmd_byte holds its last value.
- State machine, four states:
  - IDLE: on rise with din_s=1, load the start bit into the shift register, set counter=1, go to CMD. Rises with din_s=0 are ignored (leading zeros).
  - CMD: on each rise, shift din_s into the LSB and increment the counter.
    - On the rise that completes 8 bits: store cmd_byte and decode addr = byte[6:4].
    - Address map: 3'b101 selects x_value, 3'b001 selects y_value, 3'b011 selects z_value. Any other address selects 12'h000 and pulses bad_addr.
    - Latch the selected 12-bit value into the output shift register, then go to BUSY.
  - BUSY: on the first fall, assert busy=1. On the next fall, busy=0, dout=D11, counter=1, go to DATA.
  - DATA: on each fall while counter<12, drive the next bit (MSB first) and increment. After D0 has been held through the following rise, the next fall sets dout=0, pulses frame_done, and returns to IDLE.
    - That same fall is the first falling edge of the next frame.
- Mode, SER/DFR and PD bits (byte[3:0]) are captured in cmd_byte but ignored; the data phase is always 12 bits.
- Rising edges during BUSY and DATA are ignored as command bits. The controller sends nothing until the result is read.
- The sample value is latched once per frame at the 8th rise. x/y/z_value changes after that point do not affect the frame in flight.

## Timing
- Reset values:
  - dout=0, busy=0, frame_done=0, bad_addr=0.
  - cmd_byte=8'h00, state IDLE, all synchronizers 0.
  - csb synchronizer resets to 1.
- Input-edge to internal-action latency: SYNC_STAGES+1 cclk cycles (3 by default).
- dout and busy update within SYNC_STAGES+1 cclk of an sclk falling edge. They are stable before the next rising edge when the sclk half-period is at least SYNC_STAGES+2 cclk. The controller's /25 divider satisfies this.
- bad_addr pulses on the cclk the 8th rise is processed. frame_done pulses on the cclk the post-D0 fall is processed.
- Each pulse is high for exactly one cclk.
- Simultaneous csb_s rising with a sclk edge: csb wins; the edge is discarded.
- rst asserted mid-frame: outputs return to reset values immediately (asynchronously). After release, the responder hunts for a fresh start bit.

## Test plan
- Load x_value=12'hA5C and send control byte 8'hD3. Required: cmd_byte=8'hD3, busy high for exactly one sclk period, then dout shifts 1010_0101_1100 MSB first on falling edges, then one frame_done pulse.
- Send Y read 8'h93 with y_value=12'h3F1, then Z read 8'hB3 with z_value=12'h801, back-to-back with csb held low. Required: the controller receives 12'h3F1 then 12'h801, with two frame_done pulses.
- Send control byte 8'hF3 (address 3'b111). Required: bad_addr pulses once, data reads 12'h000, frame completes normally.
- Send five leading zero bits, then 8'hD3. Required: the zeros are ignored and the frame decodes as an X read.
- Deassert csb after 5 data bits. Required: within 3 cclk dout=0 and busy=0, with no frame_done. The next frame after csb returns low decodes correctly.
- Assert rst during BUSY. Required: busy drops to 0 asynchronously. A full X read after release returns x_value intact.
